// File: rtl/alu_arbiter.sv
// Two-requester arbiter for a shared combinational ALU: IDLE -> EXEC -> DONE, round-robin grant.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win simultaneous requests.
module alu_arbiter #(
    parameter int N     = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [SEL_W-1:0] op0,
    input  logic [SEL_W-1:0] op1,
    input  logic [N-1:0]     x0,
    input  logic [N-1:0]     x1,
    input  logic [N-1:0]     y0,
    input  logic [N-1:0]     y1,
    output logic             done0,
    output logic             done1,
    output logic [N-1:0]     res,
    output logic [2:0]       flags,
    output logic             busy,
    output logic [N-1:0]     alu_rx,
    output logic [N-1:0]     alu_ry,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [N-1:0]     alu_r0,
    input  logic [2:0]       alu_flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic       gnt;
    logic       win;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = !req0;
`else
    logic prio;
    // prio only breaks ties; a lone requester always wins
    assign win = (req0 && req1) ? prio : req1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gnt     <= 1'b0;
            alu_sel <= '0;
            alu_rx  <= '0;
            alu_ry  <= '0;
            res     <= '0;
            flags   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt     <= win;
                        alu_sel <= win ? op1 : op0;
                        alu_rx  <= win ? x1  : x0;
                        alu_ry  <= win ? y1  : y0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res   <= alu_r0;
                    flags <= alu_flags;
                    state <= S_DONE;
                end
                S_DONE: begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                    prio  <= ~gnt;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done0 = (state == S_DONE) && !gnt;
    assign done1 = (state == S_DONE) &&  gnt;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level scheduling model checked every cycle,
// directed scenarios followed by random request traffic.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rq [2];
    logic [3:0] opv [2];
    logic [7:0] xv [2];
    logic [7:0] yv [2];
    logic       done0, done1, busy;
    logic [7:0] res, alu_rx, alu_ry, alu_r0;
    logic [2:0] flags, alu_flags;
    logic [3:0] alu_sel;

    always #5 clk = ~clk;

    function automatic logic [10:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = (s == 4'd0) ? a + b : (s == 4'd1) ? b - a : a ^ b;
        return {1'b0, r[7], r == 8'd0, r};
    endfunction

    assign {alu_flags, alu_r0} = alu_f(alu_sel, alu_rx, alu_ry);

    alu_arbiter #(.N(8), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .req1(rq[1]),
        .op0(opv[0]), .op1(opv[1]),
        .x0(xv[0]), .x1(xv[1]), .y0(yv[0]), .y1(yv[1]),
        .done0(done0), .done1(done1), .res(res), .flags(flags), .busy(busy),
        .alu_rx(alu_rx), .alu_ry(alu_ry), .alu_sel(alu_sel),
        .alu_r0(alu_r0), .alu_flags(alu_flags)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // requester agents: ops still to issue, back-to-back mode, preset operands
    int         left [2];
    bit         cont [2];
    bit         fix  [2];
    logic [3:0] fop  [2];
    logic [7:0] fx   [2];
    logic [7:0] fy   [2];

    // model: one transaction in flight, described by its exec/done cycle numbers
    int         free_at, exec_c, done_c, gnt_m, prio_m;
    logic [7:0] res_m, sel_rx, sel_ry, pend_res;
    logic [2:0] flags_m, pend_flags;
    logic [3:0] sel_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exec_c = -10; done_c = -10; free_at = 1 << 30;
        gnt_m = 0; prio_m = 0;
        res_m = '0; flags_m = '0; sel_m = '0; sel_rx = '0; sel_ry = '0;
    endtask

    task automatic check_outputs(input int c);
        if (c == done_c) begin
            res_m   = pend_res;
            flags_m = pend_flags;
        end
        chk("busy",    32'(busy),    32'((c == exec_c) || (c == done_c)));
        chk("done0",   32'(done0),   32'((c == done_c) && gnt_m == 0));
        chk("done1",   32'(done1),   32'((c == done_c) && gnt_m == 1));
        chk("res",     32'(res),     32'(res_m));
        chk("flags",   32'(flags),   32'(flags_m));
        chk("alu_sel", 32'(alu_sel), 32'(sel_m));
        chk("alu_rx",  32'(alu_rx),  32'(sel_rx));
        chk("alu_ry",  32'(alu_ry),  32'(sel_ry));
    endtask

    task automatic agent(input int c);
        for (int k = 0; k < 2; k++) begin
            if (c == done_c && gnt_m == k) rq[k] = 1'b0;
            if (!rq[k]) begin
                // idle requesters scramble their operands; the block must ignore them
                opv[k] = 4'($urandom_range(3, 0));
                xv[k]  = 8'($urandom);
                yv[k]  = 8'($urandom);
                if (left[k] > 0 && (cont[k] || $urandom_range(2, 0) == 0)) begin
                    rq[k] = 1'b1;
                    left[k]--;
                    if (fix[k]) begin
                        opv[k] = fop[k]; xv[k] = fx[k]; yv[k] = fy[k]; fix[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic arb(input int c);
        int w;
        if (rst_n && c >= free_at && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) w = FIXED ? 0 : prio_m;
            else                w = rq[1] ? 1 : 0;
            gnt_m  = w;
            sel_m  = opv[w]; sel_rx = xv[w]; sel_ry = yv[w];
            {pend_flags, pend_res} = alu_f(sel_m, sel_rx, sel_ry);
            exec_c = c + 1; done_c = c + 2; free_at = c + 3;
            if (!FIXED) prio_m = 1 - w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs(cyc);
        agent(cyc);
        arb(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(cyc);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        free_at = cyc;
        arb(cyc);
    endtask

    task automatic preset(input int k, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        fix[k] = 1'b1; fop[k] = o; fx[k] = a; fy[k] = b;
        left[k] = 1; cont[k] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rq[k] = 1'b0; opv[k] = '0; xv[k] = '0; yv[k] = '0;
            left[k] = 0; cont[k] = 1'b0; fix[k] = 1'b0;
            fop[k] = '0; fx[k] = '0; fy[k] = '0;
        end
        pend_res = '0; pend_flags = '0;
        model_reset();
        #2;
        check_outputs(cyc);
        @(negedge clk);
        release_reset();

        // single req0 add: alu drive at t+1, done0 with res 08 at t+2
        preset(0, 4'd0, 8'h05, 8'h03);
        tick();
        tick();
        chk("r030_sel", 32'(alu_sel), 32'h0);
        chk("r030_rx",  32'(alu_rx),  32'h05);
        chk("r030_ry",  32'(alu_ry),  32'h03);
        tick();
        chk("r030_done0", 32'(done0), 32'h1);
        chk("r030_done1", 32'(done1), 32'h0);
        chk("r030_res",   32'(res),   32'h08);
        chk("r030_flags", 32'(flags), 32'h0);
        run(3);

        // simultaneous requests straight out of reset
        preset(0, 4'd0, 8'h01, 8'h01);
        preset(1, 4'd1, 8'h04, 8'h04);
        apply_reset();
        tick();
        release_reset();
        tick();
        tick();
        chk("r031_done0", 32'(done0), 32'h1);
        chk("r031_res0",  32'(res),   32'h02);
        run(3);
        chk("r031_done1", 32'(done1), 32'h1);
        chk("r031_res1",  32'(res),   32'h00);
        chk("r031_zero",  32'(flags[0]), 32'h1);
        run(2);

        // continuous contention, eight operations
        left[0] = 4; left[1] = 4; cont[0] = 1'b1; cont[1] = 1'b1;
        run(30);

        // req1 arrives while req0 is executing
        preset(0, 4'd1, 8'h10, 8'h20);
        tick();
        tick();
        preset(1, 4'd0, 8'h33, 8'h44);
        agent(cyc);
        arb(cyc);
        tick();
        chk("r034_res0", 32'(res), 32'h10);
        tick();
        chk("r034_hold", 32'(res), 32'h10);
        run(6);

        // reset in the EXEC cycle of a req1 operation
        preset(1, 4'd0, 8'h21, 8'h12);
        tick();
        tick();
        apply_reset();
        chk("r033_busy",  32'(busy),  32'h0);
        chk("r033_done1", 32'(done1), 32'h0);
        chk("r033_rx",    32'(alu_rx), 32'h0);
        run(2);
        release_reset();
        tick();
        tick();
        chk("r033_done1b", 32'(done1), 32'h1);
        chk("r033_res",    32'(res),   32'h33);
        run(3);

        // random traffic with a reset in the middle
        for (int r = 0; r < 2; r++) begin
            left[0] = $urandom_range(25, 15); left[1] = $urandom_range(25, 15);
            cont[0] = 1'b0; cont[1] = 1'b0;
            run(200 + $urandom_range(20, 0));
            apply_reset();
            tick();
            release_reset();
        end
        left[0] = 0; left[1] = 0;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
